// File: rtl/uart_tx_serializer.sv
// UART transmit serializer with a one-entry holding register.
//
// A word offered on in_valid/in_data is captured into the holding register
// whenever it is empty (in_ready high). On the next clk_baud pulse the
// serializer loads the word into its shift register and sends a frame:
// start bit (0), DATA_BITS data bits LSB first, optional parity bit, then
// STOP_BITS stop bits (1). A new word can be taken into the holding register
// mid-frame, and it follows the stop bit(s) directly with no idle bit.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   reset       asynchronous active-high reset
//   clk_baud    one-clk-wide enable, one pulse per bit period
//   in_valid    parallel word offered
//   in_data     parallel word
//   in_ready    holding register empty
//   serial_out  registered UART line, idle high
//   busy        a frame is in progress
//   tx_done     one-clk pulse after the edge that ends the last stop bit
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_baud,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam int unsigned   CntW     = 4;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);
  localparam logic          LastStop = 1'(STOP_BITS - 1);
  localparam logic          OddPar   = (PARITY == 2);
  localparam logic          HasPar   = (PARITY != 0);

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   hold_data_q, hold_data_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   serial_q, serial_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   load;

  // Held low during reset so nothing can be offered into a flop being cleared.
  assign in_ready   = ~hold_full_q & ~reset;
  assign accept     = in_valid & in_ready;
  assign busy       = (state_q != StIdle);
  assign serial_out = serial_q;
  assign tx_done    = done_q;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    load        = 1'b0;

    if (clk_baud) begin
      case (state_q)
        StIdle: begin
          if (hold_full_q) load = 1'b1;
        end
        StStart: begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
        StData: begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastBit) begin
            state_d    = HasPar ? StParity : StStop;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StParity: begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
        StStop: begin
          if (stop_cnt_q == LastStop) begin
            done_d = 1'b1;
            // Back-to-back: a held word starts right after the last stop bit.
            if (hold_full_q) load = 1'b1;
            else             state_d = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (load) begin
        state_d    = StStart;
        shift_d    = hold_data_q;
        // Parity is frozen at load time so later in_data changes cannot leak in.
        parity_d   = (^hold_data_q) ^ OddPar;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
      end

      // Line value for the bit period that starts at this edge.
      case (state_d)
        StStart:  serial_d = 1'b0;
        StData:   serial_d = shift_d[0];
        StParity: serial_d = parity_d;
        default:  serial_d = 1'b1;
      endcase
    end

    // load and accept are mutually exclusive: load needs a full register,
    // accept needs an empty one.
    if (load) hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      serial_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Four instances with different
// frame formats share one stimulus stream; a frame-level model (a queue of
// line bits per instance) predicts serial_out, busy, in_ready and tx_done on
// every cycle, and directed sends check captured frames against literals.
module tb_uart_tx_serializer;

  localparam int NDut = 4;
  localparam int DB [NDut] = '{8, 7, 8, 8};
  localparam int PAR[NDut] = '{0, 0, 2, 1};
  localparam int ST [NDut] = '{1, 2, 1, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_baud = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = '0;

  logic so [NDut];
  logic rdy[NDut];
  logic bsy[NDut];
  logic dn [NDut];

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .clk_baud(clk_baud), .in_valid(in_valid),
    .in_data(in_data[7:0]), .in_ready(rdy[0]), .serial_out(so[0]), .busy(bsy[0]),
    .tx_done(dn[0])
  );
  uart_tx_serializer #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .clk_baud(clk_baud), .in_valid(in_valid),
    .in_data(in_data[6:0]), .in_ready(rdy[1]), .serial_out(so[1]), .busy(bsy[1]),
    .tx_done(dn[1])
  );
  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .clk_baud(clk_baud), .in_valid(in_valid),
    .in_data(in_data[7:0]), .in_ready(rdy[2]), .serial_out(so[2]), .busy(bsy[2]),
    .tx_done(dn[2])
  );
  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d (
    .clk(clk), .reset(reset), .clk_baud(clk_baud), .in_valid(in_valid),
    .in_data(in_data[7:0]), .in_ready(rdy[3]), .serial_out(so[3]), .busy(bsy[3]),
    .tx_done(dn[3])
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, idx, $time, act, exp);
    end
  endtask

  // Line bits of one frame, index 0 sent first.
  function automatic void build(input bit [8:0] w, input int db, input int par, input int st,
                                output bit [15:0] v, output int n);
    bit p;
    v = '0;
    p = 1'b0;
    n = 1;  // start bit is 0
    for (int k = 0; k < db; k++) begin
      v[n] = w[k];
      p ^= w[k];
      n++;
    end
    if (par != 0) begin
      v[n] = (par == 2) ? ~p : p;
      n++;
    end
    for (int s = 0; s < st; s++) begin
      v[n] = 1'b1;
      n++;
    end
  endfunction

  // ---------------- reference model ----------------
  bit [15:0] fr   [NDut];  // bits still to send, fr[0] is on the line now
  int        rem  [NDut];
  bit        mfull[NDut];
  bit [8:0]  mword[NDut];
  bit        edone[NDut];
  bit        last_baud = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDut; i++) begin
        fr[i] = '0; rem[i] = 0; mfull[i] = 1'b0; edone[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NDut; i++) begin
        bit acc;
        acc = in_valid && !mfull[i];
        edone[i] = 1'b0;
        if (clk_baud) begin
          if (rem[i] > 0) begin
            fr[i] = fr[i] >> 1;
            rem[i]--;
            if (rem[i] == 0) edone[i] = 1'b1;
          end
          if (rem[i] == 0 && mfull[i]) begin
            build(mword[i], DB[i], PAR[i], ST[i], fr[i], rem[i]);
            mfull[i] = 1'b0;
          end
        end
        if (acc) begin
          mfull[i] = 1'b1;
          mword[i] = in_data;
        end
      end
    end
  end

  always @(posedge clk) last_baud <= clk_baud;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NDut; i++) begin
        chk("serial_out", i, 32'(so[i]),  32'((rem[i] > 0) ? fr[i][0] : 1'b1));
        chk("busy",       i, 32'(bsy[i]), 32'(rem[i] > 0));
        chk("in_ready",   i, 32'(rdy[i]), 32'(!mfull[i] && !reset));
        chk("tx_done",    i, 32'(dn[i]),  32'(edone[i]));
      end
    end
  end

  // Frame capture: line value after each baud edge while busy.
  bit [31:0] cap  [NDut];
  int        ncap [NDut];
  int        ndone[NDut];
  bit        cap_en = 1'b0;

  always @(negedge clk) begin
    if (cap_en) begin
      for (int i = 0; i < NDut; i++) begin
        if (last_baud && bsy[i] && ncap[i] < 32) begin
          cap[i][ncap[i]] = so[i];
          ncap[i]++;
        end
        if (dn[i]) ndone[i]++;
      end
    end
  end

  task automatic cap_start();
    for (int i = 0; i < NDut; i++) begin
      cap[i] = '0; ncap[i] = 0; ndone[i] = 0;
    end
    cap_en = 1'b1;
  endtask

  task automatic step(input bit b, input bit v, input bit [8:0] d);
    @(posedge clk);
    #2;
    clk_baud = b;
    in_valid = v;
    in_data  = d;
    cyc++;
  endtask

  // Directed stepping: baud every fourth clock.
  task automatic dstep(input bit v, input bit [8:0] d);
    step((cyc % 4) == 0, v, d);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) dstep(1'b0, 9'h0);
  endtask

  task automatic frame_chk(input string name, input int i, input bit [31:0] exp, input int n,
                           input int ndn);
    chk({name, "_bits"}, i, cap[i], exp);
    chk({name, "_len"},  i, ncap[i], n);
    chk({name, "_done"}, i, ndone[i], ndn);
  endtask

  initial begin
    bit [15:0] v;
    int        n;

    // Pin the frame builder itself.
    build(9'h55, 8, 0, 1, v, n); chk("model_55", 0, {v, 16'(n)}, {16'h02AA, 16'd10});
    build(9'hA3, 8, 1, 1, v, n); chk("model_a3e", 0, {v, 16'(n)}, {16'h0546, 16'd11});
    build(9'hA3, 8, 2, 1, v, n); chk("model_a3o", 0, {v, 16'(n)}, {16'h0746, 16'd11});
    build(9'h7F, 7, 0, 2, v, n); chk("model_7f", 0, {v, 16'(n)}, {16'h03FE, 16'd10});

    #1 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    for (int i = 0; i < NDut; i++) begin
      chk("rst_line", i, 32'(so[i]), 32'd1);
      chk("rst_ready", i, 32'(rdy[i]), 32'd0);
    end
    run(3);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NDut; i++) chk("ready_after_rst", i, 32'(rdy[i]), 32'd1);

    // Single frames.
    cap_start(); dstep(1'b1, 9'h55); run(52); cap_en = 1'b0;
    frame_chk("f55", 0, 32'h2AA, 10, 1);
    frame_chk("f55", 1, 32'h3AA, 10, 1);
    frame_chk("f55", 2, 32'h6AA, 11, 1);
    frame_chk("f55", 3, 32'h4AA, 11, 1);

    cap_start(); dstep(1'b1, 9'hA3); run(52); cap_en = 1'b0;
    frame_chk("fa3", 0, 32'h346, 10, 1);
    frame_chk("fa3", 2, 32'h746, 11, 1);
    frame_chk("fa3", 3, 32'h546, 11, 1);

    cap_start(); dstep(1'b1, 9'h7F); run(52); cap_en = 1'b0;
    frame_chk("f7f", 1, 32'h3FE, 10, 1);

    // Back-to-back with a rejected third word.
    cap_start();
    dstep(1'b1, 9'h00);
    run(8);
    dstep(1'b1, 9'hFF);
    dstep(1'b0, 9'h00);
    chk("b2b_ready_low", 0, 32'(rdy[0]), 32'd0);
    for (int k = 0; k < 8; k++) dstep(1'b1, 9'h3C);
    run(104);
    cap_en = 1'b0;
    frame_chk("b2b", 0, 32'hFFA00, 20, 2);

    // Reset mid-frame, with a word also waiting in the holding register.
    dstep(1'b1, 9'h0F);
    for (int k = 0; k < 8; k++) dstep(1'b1, 9'h3C);
    dstep(1'b0, 9'h00);
    for (int k = 0; k < 100 && rem[0] != 6; k++) run(1);
    chk("reach_bit3", 0, rem[0], 6);
    reset = 1'b1;
    #1;
    for (int i = 0; i < NDut; i++) begin
      chk("async_line", i, 32'(so[i]), 32'd1);
      chk("async_busy", i, 32'(bsy[i]), 32'd0);
    end
    run(3);
    reset = 1'b0;
    cap_start(); run(60); cap_en = 1'b0;
    for (int i = 0; i < NDut; i++) chk("no_residual", i, ncap[i], 0);
    cap_start(); dstep(1'b1, 9'h81); run(52); cap_en = 1'b0;
    frame_chk("f81", 0, 32'h302, 10, 1);

    // Random traffic, random baud spacing, occasional resets.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 9'($urandom));
    end
    for (int k = 0; k < 80; k++) step($urandom_range(0, 1) == 1, 1'b0, 9'h0);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
